// File: rtl/inst_fetch_unit.sv
// RV32I fetch stage: PC, synchronous IMEM request, small fetch queue with valid/ready output.
// Optional misaligned-redirect fault tracking is enabled by defining FETCH_MISALIGN_CHECK_EN.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 2,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        fetch_fault
);

  localparam int unsigned PtrW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] occ_q, occ_d;
  logic            inflight_q, inflight_d;
  logic [31:0]     infl_pc_q, infl_pc_d;
  logic            infl_epoch_q, infl_epoch_d;
  logic            epoch_q, epoch_d;

  logic [31:0] q_inst [QUEUE_DEPTH];
  logic [31:0] q_pc   [QUEUE_DEPTH];

  logic          fault;
  logic [31:0]   fault_pc;
  logic          pop;
  logic          push;
  logic [CntW:0] pending;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fault_q;
  logic [31:0] fault_pc_q;

  // The first misaligned redirect is latched; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fault_q    <= 1'b0;
      fault_pc_q <= RESET_PC;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00) && !fault_q) begin
      fault_q    <= 1'b1;
      fault_pc_q <= redirect_pc;
    end
  end

  assign fault       = fault_q;
  assign fault_pc    = fault_pc_q;
  assign fetch_fault = fault_q;
`else
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign fault       = 1'b0;
  assign fault_pc    = RESET_PC;
  assign fetch_fault = 1'b0;
`endif

  // A coincident redirect cancels the head transfer.
  assign if_valid = rstn && !redirect_valid && !fault && (occ_q != '0);
  assign pop      = if_valid && if_ready;
  // Stale-epoch responses are wrong-path fetches and are dropped.
  assign push     = inflight_q && (infl_epoch_q == epoch_q) && !fault && !redirect_valid;

  // Slots that will be committed after this cycle; issuing needs one more free.
  assign pending  = {1'b0, occ_q} + (CntW + 1)'(inflight_q) - (CntW + 1)'(pop);
  assign imem_req = rstn && !redirect_valid && !fault &&
                    (pending < (CntW + 1)'(QUEUE_DEPTH));
  assign imem_addr = fetch_pc_q;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    occ_d        = occ_q;
    epoch_d      = epoch_q;
    inflight_d   = imem_req;
    infl_pc_d    = infl_pc_q;
    infl_epoch_d = infl_epoch_q;

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      occ_d      = '0;
      epoch_d    = ~epoch_q;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      occ_d = occ_q + CntW'(push) - CntW'(pop);
      if (imem_req) begin
        fetch_pc_d   = fetch_pc_q + 32'd4;
        infl_pc_d    = fetch_pc_q;
        infl_epoch_d = epoch_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fetch_pc_q   <= RESET_PC;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      inflight_q   <= 1'b0;
      infl_pc_q    <= RESET_PC;
      infl_epoch_q <= 1'b0;
      epoch_q      <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      inflight_q   <= inflight_d;
      infl_pc_q    <= infl_pc_d;
      infl_epoch_q <= infl_epoch_d;
      epoch_q      <= epoch_d;
    end
  end

  // Storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (rstn && push) begin
      q_inst[wr_ptr_q] <= imem_rdata;
      q_pc[wr_ptr_q]   <= infl_pc_q;
    end
  end

  assign if_inst = if_valid ? q_inst[rd_ptr_q] : NOP_INST;

  always_comb begin
    if_pc = fetch_pc_q;
    if (fault) begin
      if_pc = fault_pc;
    end else if (occ_q != '0) begin
      if_pc = q_pc[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit; IMEM word i holds the value i.
// Expectations follow FETCH_MISALIGN_CHECK_EN when it is defined.
module tb_inst_fetch_unit;

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit MisalignOn = 1'b1;
`else
  localparam bit MisalignOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        fetch_fault;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] log_pc[$];

  inst_fetch_unit dut (
    .clk           (clk),
    .rstn          (rstn),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_inst       (if_inst),
    .if_pc         (if_pc),
    .fetch_fault   (fetch_fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr >> 2;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic begin_cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
    if_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  task automatic end_cycle();
    if (if_valid && if_ready) log_pc.push_back(if_pc);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn           = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req",   32'(imem_req),    32'h0);
    check("rst_valid", 32'(if_valid),    32'h0);
    check("rst_inst",  if_inst,          32'h0000_0013);
    check("rst_pc",    if_pc,            32'h0);
    check("rst_fault", 32'(fetch_fault), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    log_pc.delete();
  endtask

  task automatic check_log(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] exp [4];
    exp = '{e0, e1, e2, e3};
    check({tag, "_n"}, 32'(log_pc.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_pc"}, (i < log_pc.size()) ? log_pc[i] : 32'hDEAD_BEEF, exp[i]);
    end
  endtask

  initial begin
    rstn           = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    @(negedge clk);

    // Streaming, then backpressure over cycles 3..7.
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      begin_cycle(!(c >= 3 && c <= 7), 1'b0, 32'h0);
      case (c)
        0: begin
          check("t1_req0",  32'(imem_req), 32'h1);
          check("t1_addr0", imem_addr,     32'h0);
          check("t1_v0",    32'(if_valid), 32'h0);
        end
        1: begin
          check("t1_addr1", imem_addr,     32'h4);
          check("t1_v1",    32'(if_valid), 32'h0);
        end
        2: begin
          check("t1_v2",    32'(if_valid), 32'h1);
          check("t1_pc2",   if_pc,         32'h0);
          check("t1_inst2", if_inst,       32'h0);
          check("t1_addr2", imem_addr,     32'h8);
        end
        3, 4, 5, 6, 7: begin
          check("t2_req_stall", 32'(imem_req), 32'h0);
          check("t2_v_stall",   32'(if_valid), 32'h1);
          check("t2_pc_hold",   if_pc,         32'h4);
          check("t2_inst_hold", if_inst,       32'h1);
        end
        8: begin
          check("t2_req8",  32'(imem_req), 32'h1);
          check("t2_addr8", imem_addr,     32'hC);
          check("t2_pc8",   if_pc,         32'h4);
        end
        9:  check("t2_pc9",  if_pc, 32'h8);
        10: begin
          check("t2_pc10",   if_pc,   32'hC);
          check("t2_inst10", if_inst, 32'h3);
        end
        default: ;
      endcase
      end_cycle();
    end
    check_log("t2_log", 32'h0, 32'h4, 32'h8, 32'hC);

    // Redirect with a fetch in flight, redirects during a transfer, then reset mid-stream.
    do_reset();
    for (int c = 0; c <= 15; c++) begin
      rstn = (c != 12);
      begin_cycle(c >= 3, (c == 2) || (c == 6) || (c == 7),
                  (c == 2) ? 32'h40 : ((c == 6) ? 32'h80 : 32'hC0));
      case (c)
        2: begin
          check("t3_v_redir",   32'(if_valid), 32'h0);
          check("t3_req_redir", 32'(imem_req), 32'h0);
        end
        3: begin
          check("t3_req3",  32'(imem_req), 32'h1);
          check("t3_addr3", imem_addr,     32'h40);
          check("t3_v3",    32'(if_valid), 32'h0);
        end
        4: check("t3_v4", 32'(if_valid), 32'h0);
        5: begin
          check("t3_v5",    32'(if_valid), 32'h1);
          check("t3_pc5",   if_pc,         32'h40);
          check("t3_inst5", if_inst,       32'h10);
        end
        6, 7: begin
          check("t4_v_redir",   32'(if_valid), 32'h0);
          check("t4_req_redir", 32'(imem_req), 32'h0);
        end
        8: check("t4_addr8", imem_addr,     32'hC0);
        9: check("t4_v9",    32'(if_valid), 32'h0);
        10: begin
          check("t4_v10",    32'(if_valid), 32'h1);
          check("t4_pc10",   if_pc,         32'hC0);
          check("t4_inst10", if_inst,       32'h30);
        end
        11: check("t4_pc11", if_pc, 32'hC4);
        12: begin
          check("t5_v_rst",   32'(if_valid), 32'h0);
          check("t5_req_rst", 32'(imem_req), 32'h0);
        end
        13: begin
          check("t5_v13",    32'(if_valid), 32'h0);
          check("t5_addr13", imem_addr,     32'h0);
          check("t5_pc13",   if_pc,         32'h0);
        end
        14: check("t5_v14", 32'(if_valid), 32'h0);
        15: begin
          check("t5_pc15",   if_pc,   32'h0);
          check("t5_inst15", if_inst, 32'h0);
        end
        default: ;
      endcase
      end_cycle();
    end
    rstn = 1'b1;
    check_log("t4_log", 32'h40, 32'hC0, 32'hC4, 32'h0);

    // Misaligned redirect.
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      begin_cycle(1'b1, c == 2, 32'h42);
      if (c == 2) check("t6_v_redir", 32'(if_valid), 32'h0);
      if (c == 3) begin
        check("t6_req3",   32'(imem_req),    MisalignOn ? 32'h0 : 32'h1);
        check("t6_fault3", 32'(fetch_fault), MisalignOn ? 32'h1 : 32'h0);
        if (!MisalignOn) check("t6_addr3", imem_addr, 32'h40);
      end
      if (c == 5) begin
        check("t6_v5",     32'(if_valid),    MisalignOn ? 32'h0 : 32'h1);
        check("t6_pc5",    if_pc,            MisalignOn ? 32'h42 : 32'h40);
        check("t6_req5",   32'(imem_req),    MisalignOn ? 32'h0 : 32'h1);
        check("t6_fault5", 32'(fetch_fault), MisalignOn ? 32'h1 : 32'h0);
      end
      end_cycle();
    end

    // PC wrap at the top of the address space.
    do_reset();
    for (int c = 0; c <= 4; c++) begin
      begin_cycle(1'b1, c == 0, 32'hFFFF_FFFC);
      case (c)
        0: check("wrap_req0",  32'(imem_req), 32'h0);
        1: check("wrap_addr1", imem_addr,     32'hFFFF_FFFC);
        2: check("wrap_addr2", imem_addr,     32'h0);
        3: begin
          check("wrap_pc3",   if_pc,   32'hFFFF_FFFC);
          check("wrap_inst3", if_inst, 32'h3FFF_FFFF);
        end
        4: check("wrap_pc4", if_pc, 32'h0);
        default: ;
      endcase
      end_cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
